// File: rtl/dmem_stage_if.sv
// Data-memory request/response bus between dmem_stage and memory.
// master = pipeline stage, slave = memory.
interface dmem_stage_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic [AWIDTH-1:0]     dmem_addr;
    logic                  dmem_we;
    logic [DWIDTH-1:0]     dmem_wdata;
    logic [DWIDTH/8-1:0]   dmem_wstrb;
    logic                  dmem_rsp_valid;
    logic [DWIDTH-1:0]     dmem_rsp_data;

    modport master (
        output dmem_req_valid,
        output dmem_addr,
        output dmem_we,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        input  dmem_rsp_data
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_req_ready,
        output dmem_rsp_valid,
        output dmem_rsp_data
    );
endinterface

// File: rtl/dmem_stage.sv
// pd3 memory-access stage: ALU pass-through, load/store via dmem bus.
// One instruction in flight; misaligned/illegal accesses fault locally.
module dmem_stage #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [AWIDTH-1:0] e_res,
    input  logic [DWIDTH-1:0] e_rs2data,
    input  logic [2:0]        e_funct3,
    input  logic              e_memren,
    input  logic              e_memwen,
    input  logic [4:0]        e_rd,
    input  logic              e_regwen,
    dmem_stage_if.master      dmem,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [4:0]        m_rd,
    output logic              m_regwen,
    output logic              m_fault
);
    localparam int NB = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              req_valid;
    logic [AWIDTH-1:0] a_addr;
    logic [2:0]        a_f3;
    logic [4:0]        a_rd;
    logic              a_regwen;
    logic              a_we;
    logic [DWIDTH-1:0] a_wdata;
    logic [NB-1:0]     a_wstrb;

    logic              accept, memop, fault, issue;
    logic              is_half, is_word, bad_f3;
    logic [DWIDTH-1:0] st_wdata;
    logic [NB-1:0]     st_wstrb;
    logic [DWIDTH-1:0] shifted, ld_data;

    assign e_ready = (state_q == IDLE) && (!m_valid || m_ready);
    assign accept  = e_valid && e_ready;
    assign memop   = e_memren || e_memwen;
    assign is_half = (e_funct3[1:0] == 2'b01);
    assign is_word = (e_funct3[1:0] == 2'b10);
    assign bad_f3  = (e_funct3 == 3'b011) || (e_funct3 == 3'b110)
                  || (e_funct3 == 3'b111);
    assign fault   = (e_memren && e_memwen) || bad_f3
                  || (e_memwen && (e_funct3 > 3'b010))
                  || (is_half && e_res[0])
                  || (is_word && (e_res[1:0] != 2'b00));
    assign issue   = accept && memop && !fault;

    assign dmem.dmem_req_valid = req_valid;
    assign dmem.dmem_addr      = {a_addr[AWIDTH-1:2], 2'b00};
    assign dmem.dmem_we        = req_valid && a_we;
    assign dmem.dmem_wdata     = a_wdata;
    assign dmem.dmem_wstrb     = req_valid ? a_wstrb : '0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and request-valid decode
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        unique case (state_q)
            IDLE: if (issue) state_d = REQ;
            REQ: begin
                req_valid = 1'b1;
                if (dmem.dmem_req_ready) state_d = a_we ? IDLE : WAIT;
            end
            WAIT: if (dmem.dmem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store lane replication and byte strobes from the offered address
    always_comb begin
        st_wdata = e_rs2data;
        st_wstrb = '1;
        unique case (e_funct3[1:0])
            2'b00: begin
                st_wdata = {NB{e_rs2data[7:0]}};
                st_wstrb = NB'(1) << e_res[1:0];
            end
            2'b01: begin
                st_wdata = {(NB/2){e_rs2data[15:0]}};
                st_wstrb = NB'(3) << e_res[1:0];
            end
            default: ;
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        shifted = dmem.dmem_rsp_data >> {a_addr[1:0], 3'b000};
        ld_data = shifted;
        unique case (a_f3)
            3'b000: ld_data = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001: ld_data = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100: ld_data = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
            3'b101: ld_data = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

    // Latch the memory access when it is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_addr   <= '0;
            a_f3     <= '0;
            a_rd     <= '0;
            a_regwen <= 1'b0;
            a_we     <= 1'b0;
            a_wdata  <= '0;
            a_wstrb  <= '0;
        end else if (issue) begin
            a_addr   <= e_res;
            a_f3     <= e_funct3;
            a_rd     <= e_rd;
            a_regwen <= e_regwen;
            a_we     <= e_memwen;
            a_wdata  <= e_memwen ? st_wdata : '0;
            a_wstrb  <= e_memwen ? st_wstrb : '0;
        end
    end

    // Writeback output register, held until consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_rd     <= '0;
            m_regwen <= 1'b0;
            m_fault  <= 1'b0;
        end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (accept && (!memop || fault)) begin
                m_valid  <= 1'b1;
                m_data   <= DWIDTH'(e_res);
                m_rd     <= e_rd;
                m_regwen <= !memop && e_regwen && (e_rd != 5'd0);
                m_fault  <= memop;
            end else if (state_q == REQ && dmem.dmem_req_ready && a_we) begin
                m_valid  <= 1'b1;
                m_data   <= DWIDTH'(a_addr);
                m_rd     <= a_rd;
                m_regwen <= 1'b0;
                m_fault  <= 1'b0;
            end else if (state_q == WAIT && dmem.dmem_rsp_valid) begin
                m_valid  <= 1'b1;
                m_data   <= ld_data;
                m_rd     <= a_rd;
                m_regwen <= a_regwen && (a_rd != 5'd0);
                m_fault  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: vector table plus stall/reset sequences.
// Memory model answers loads one cycle after the request handshake.
module tb_dmem_stage;
    typedef struct {
        logic [31:0] res;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        ren;
        logic        wen;
        logic [4:0]  rd;
        logic        regwen;
        logic [31:0] word;
        logic [31:0] x_data;
        logic        x_regwen;
        logic        x_fault;
        logic        x_req;
        logic [31:0] x_addr;
        logic [3:0]  x_wstrb;
        logic [31:0] x_wdata;
        int          x_lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_res;
    logic [31:0] e_rs2data;
    logic [2:0]  e_funct3;
    logic        e_memren;
    logic        e_memwen;
    logic [4:0]  e_rd;
    logic        e_regwen;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_regwen;
    logic        m_fault;

    logic        rsp_en;
    logic        resp_v;
    logic [31:0] resp_d;
    logic        pulse_v;
    logic [31:0] mem_word;

    int checks;
    int failures;

    vec_t v [17];

    dmem_stage_if bus ();

    dmem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_ready   (e_ready),
        .e_res     (e_res),
        .e_rs2data (e_rs2data),
        .e_funct3  (e_funct3),
        .e_memren  (e_memren),
        .e_memwen  (e_memwen),
        .e_rd      (e_rd),
        .e_regwen  (e_regwen),
        .dmem      (bus),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_rd      (m_rd),
        .m_regwen  (m_regwen),
        .m_fault   (m_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dmem_rsp_valid = resp_v | pulse_v;
    assign bus.dmem_rsp_data  = pulse_v ? 32'hDEAD0000 : resp_d;

    // Memory model: answer loads the cycle after the request handshake
    always @(posedge clk) begin
        resp_v <= rsp_en && bus.dmem_req_valid && bus.dmem_req_ready
                  && !bus.dmem_we;
        resp_d <= mem_word;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] rs2,
                         input logic [2:0] f3, input logic ren,
                         input logic wen, input logic [4:0] rd,
                         input logic rw);
        e_valid   = 1'b1;
        e_res     = res;
        e_rs2data = rs2;
        e_funct3  = f3;
        e_memren  = ren;
        e_memwen  = wen;
        e_rd      = rd;
        e_regwen  = rw;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int          k;
        int          lat;
        logic        saw, got;
        logic [31:0] ra;
        logic [31:0] rwd;
        logic [3:0]  rs;
        logic        rwe;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        rw, fl;
        saw = 1'b0; got = 1'b0; lat = -1;
        ra = '0; rwd = '0; rs = '0; rwe = 1'b0;
        d = '0; rd = '0; rw = 1'b0; fl = 1'b0;
        mem_word = t.word;
        @(negedge clk);
        drive(t.res, t.rs2, t.f3, t.ren, t.wen, t.rd, t.regwen);
        k = 0;
        while (!e_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_accept", idx), 32'(k < 50), 32'd1);
        @(negedge clk);
        e_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.dmem_req_valid && !saw) begin
                saw = 1'b1;
                ra  = bus.dmem_addr;
                rwd = bus.dmem_wdata;
                rs  = bus.dmem_wstrb;
                rwe = bus.dmem_we;
            end
            if (m_valid) begin
                got = 1'b1;
                lat = c;
                d   = m_data;
                rd  = m_rd;
                rw  = m_regwen;
                fl  = m_fault;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_mvalid", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(t.x_lat));
        chk($sformatf("v%0d_data", idx), d, t.x_data);
        chk($sformatf("v%0d_rd", idx), 32'(rd), 32'(t.rd));
        chk($sformatf("v%0d_regwen", idx), 32'(rw), 32'(t.x_regwen));
        chk($sformatf("v%0d_fault", idx), 32'(fl), 32'(t.x_fault));
        chk($sformatf("v%0d_req", idx), 32'(saw), 32'(t.x_req));
        if (t.x_req) begin
            chk($sformatf("v%0d_addr", idx), ra, t.x_addr);
            chk($sformatf("v%0d_wstrb", idx), 32'(rs), 32'(t.x_wstrb));
            chk($sformatf("v%0d_we", idx), 32'(rwe), 32'(t.wen));
            if (t.wen) chk($sformatf("v%0d_wdata", idx), rwd, t.x_wdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        e_valid  = 1'b0;
        e_res    = '0;
        e_rs2data = '0;
        e_funct3 = '0;
        e_memren = 1'b0;
        e_memwen = 1'b0;
        e_rd     = '0;
        e_regwen = 1'b0;
        m_ready  = 1'b1;
        rsp_en   = 1'b1;
        pulse_v  = 1'b0;
        mem_word = '0;
        bus.dmem_req_ready = 1'b1;

        //        res           rs2           f3      ren   wen   rd     rw    word
        //        x_data        x_rw  x_flt x_req x_addr        x_wstrb  x_wdata  lat
        v[0]  = '{32'd150, 32'h0, 3'b000, 1'b0, 1'b0, 5'd10, 1'b1, 32'h0,
                  32'd150, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[1]  = '{32'd200, 32'h0, 3'b000, 1'b0, 1'b0, 5'd11, 1'b1, 32'h0,
                  32'd200, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[2]  = '{32'd5, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0,
                  32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[3]  = '{32'h102, 32'hAB, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,
                  32'h102, 1'b0, 1'b0, 1'b1, 32'h100, 4'b0100,
                  32'hABABABAB, 1};
        v[4]  = '{32'h102, 32'h1234CDEF, 3'b001, 1'b0, 1'b1, 5'd7, 1'b1,
                  32'h0, 32'h102, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1100,
                  32'hCDEFCDEF, 1};
        v[5]  = '{32'h104, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0,
                  32'h0, 32'h104, 1'b0, 1'b0, 1'b1, 32'h104, 4'b1111,
                  32'hDEADBEEF, 1};
        v[6]  = '{32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 5'd5, 1'b1,
                  32'h80FF1234, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};
        v[7]  = '{32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 5'd5, 1'b1,
                  32'h80FF1234, 32'h00000080, 1'b1, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};
        v[8]  = '{32'h102, 32'h0, 3'b001, 1'b1, 1'b0, 5'd6, 1'b1,
                  32'h80FF1234, 32'hFFFF80FF, 1'b1, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};
        v[9]  = '{32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd7, 1'b1,
                  32'h80FF1234, 32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};
        v[10] = '{32'h100, 32'h0, 3'b101, 1'b1, 1'b0, 5'd8, 1'b1,
                  32'h80FF1234, 32'h00001234, 1'b1, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};
        v[11] = '{32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0,
                  32'h102, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[12] = '{32'h101, 32'h0, 3'b001, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0,
                  32'h101, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[13] = '{32'h200, 32'h0, 3'b010, 1'b1, 1'b1, 5'd4, 1'b1, 32'h0,
                  32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[14] = '{32'h200, 32'h55, 3'b100, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0,
                  32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[15] = '{32'h200, 32'h0, 3'b011, 1'b1, 1'b0, 5'd4, 1'b1, 32'h0,
                  32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 0};
        v[16] = '{32'h101, 32'h0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b1,
                  32'h80FF1234, 32'h00000012, 1'b0, 1'b0, 1'b1, 32'h100,
                  4'h0, 32'h0, 2};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_e_ready", 32'(e_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_req_valid", 32'(bus.dmem_req_valid), 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        chk("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);

        // back-to-back ALU ops, one per cycle
        drive(32'd150, 32'h0, 3'b000, 1'b0, 1'b0, 5'd10, 1'b1);
        @(negedge clk);
        chk("b2b_v1", 32'(m_valid), 32'd1);
        chk("b2b_d1", m_data, 32'd150);
        chk("b2b_rw1", 32'(m_regwen), 32'd1);
        chk("b2b_ready", 32'(e_ready), 32'd1);
        drive(32'd200, 32'h0, 3'b000, 1'b0, 1'b0, 5'd11, 1'b1);
        @(negedge clk);
        e_valid = 1'b0;
        chk("b2b_v2", 32'(m_valid), 32'd1);
        chk("b2b_d2", m_data, 32'd200);
        chk("b2b_rd2", 32'(m_rd), 32'd11);

        for (int i = 0; i < 17; i++) run_vec(v[i], i);

        // request stall then writeback back-pressure
        @(negedge clk);
        bus.dmem_req_ready = 1'b0;
        drive(32'h108, 32'h11223344, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        e_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stl_rv%0d", i), 32'(bus.dmem_req_valid), 32'd1);
            chk($sformatf("stl_ad%0d", i), bus.dmem_addr, 32'h108);
            chk($sformatf("stl_wd%0d", i), bus.dmem_wdata, 32'h11223344);
            chk($sformatf("stl_st%0d", i), 32'(bus.dmem_wstrb), 32'hF);
            chk($sformatf("stl_er%0d", i), 32'(e_ready), 32'd0);
            if (i < 3) @(negedge clk);
        end
        bus.dmem_req_ready = 1'b1;
        m_ready = 1'b0;
        drive(32'd77, 32'h0, 3'b000, 1'b0, 1'b0, 5'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("hld_mv%0d", i), 32'(m_valid), 32'd1);
            chk($sformatf("hld_md%0d", i), m_data, 32'h108);
            chk($sformatf("hld_rw%0d", i), 32'(m_regwen), 32'd0);
            chk($sformatf("hld_er%0d", i), 32'(e_ready), 32'd0);
            chk($sformatf("hld_rv%0d", i), 32'(bus.dmem_req_valid), 32'd0);
        end
        m_ready = 1'b1;
        #1;
        chk("hld_release_er", 32'(e_ready), 32'd1);
        @(negedge clk);
        e_valid = 1'b0;
        chk("hld_next_mv", 32'(m_valid), 32'd1);
        chk("hld_next_md", m_data, 32'd77);
        chk("hld_next_rd", 32'(m_rd), 32'd3);

        // reset while waiting for load data, then a late response
        @(negedge clk);
        rsp_en = 1'b0;
        drive(32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
        @(negedge clk);
        e_valid = 1'b0;
        @(negedge clk);
        chk("wait_no_req", 32'(bus.dmem_req_valid), 32'd0);
        chk("wait_no_mv", 32'(m_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("ar_m_valid", 32'(m_valid), 32'd0);
        chk("ar_m_data", m_data, 32'd0);
        chk("ar_m_rd", 32'(m_rd), 32'd0);
        chk("ar_m_regwen", 32'(m_regwen), 32'd0);
        chk("ar_m_fault", 32'(m_fault), 32'd0);
        chk("ar_req_valid", 32'(bus.dmem_req_valid), 32'd0);
        chk("ar_we", 32'(bus.dmem_we), 32'd0);
        chk("ar_addr", bus.dmem_addr, 32'd0);
        chk("ar_wdata", bus.dmem_wdata, 32'd0);
        chk("ar_wstrb", 32'(bus.dmem_wstrb), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_v = 1'b1;
        @(negedge clk);
        pulse_v = 1'b0;
        chk("late_mv", 32'(m_valid), 32'd0);
        chk("late_er", 32'(e_ready), 32'd1);
        @(negedge clk);
        chk("late_mv2", 32'(m_valid), 32'd0);
        rsp_en = 1'b1;
        run_vec('{32'd321, 32'h0, 3'b000, 1'b0, 1'b0, 5'd9, 1'b1, 32'h0,
                  32'd321, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_stage.md
# dmem_stage

Memory-access stage of the pd3 pipeline, sitting directly downstream of execute and upstream of writeback. Accepts one execute result per handshake, passes ALU results through, and for loads/stores drives a valid/ready data-memory request, aligns and sign/zero-extends load data, and generates byte strobes for stores. Misaligned or illegal accesses are flagged and never reach memory. One instruction is in flight at a time.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width (byte lanes = DWIDTH/8 = 4)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- e_valid  in  1  execute offers an instruction
- e_ready  out  1  stage accepts this cycle
- e_res  in  AWIDTH  ALU result / effective address
- e_rs2data  in  DWIDTH  store data
- e_funct3  in  3  access size/sign
- e_memren, e_memwen  in  1 each  load / store
- e_rd  in  5  destination register
- e_regwen  in  1  writes rd
- dmem_req_valid  out  1  request pending
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  AWIDTH  word-aligned address ({addr[AWIDTH-1:2],2'b00})
- dmem_we  out  1  1 = store
- dmem_wdata  out  DWIDTH  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_data  in  DWIDTH  word read
- m_valid  out  1  result held for writeback
- m_ready  in  1  writeback consumes
- m_data  out  DWIDTH  result
- m_rd  out  5  destination
- m_regwen  out  1  write enable to register file
- m_fault  out  1  misaligned/illegal access

## Operation
- FSM: IDLE, REQ, WAIT. Output register (m_*) is separate, holds until m_valid&&m_ready.
- e_ready = (state==IDLE) && (!m_valid || m_ready).
- IDLE, accept with memren=memwen=0: m_data<=e_res, m_rd/m_regwen copied, m_fault=0, m_valid<=1; stay IDLE.
- IDLE, accept with memory op: latch addr, funct3, rd, regwen, data. Fault if memren&&memwen; funct3 in {011,110,111}; store funct3 >010; half with addr[0]=1; word with addr[1:0]!=0. Fault: m_valid<=1, m_fault=1, m_regwen=0, m_data=e_res, no request, stay IDLE. Otherwise -> REQ.
- REQ: dmem_req_valid=1, addr/we/wdata/wstrb stable from latched regs until dmem_req_valid&&dmem_req_ready. Store handshake -> m_valid<=1, m_regwen=0, m_data=addr, IDLE. Load handshake -> WAIT.
- WAIT: on dmem_rsp_valid, select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; m_valid<=1, m_regwen=latched regwen; -> IDLE. rsp_valid in IDLE/REQ ignored.
- Store strobes: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111. wdata: SB {4{byte}}, SH {2{half}}, SW word.
- rd=0 loads still issue; m_regwen forced 0 when m_rd==0.

## Timing
- Reset (async, any state): state IDLE, m_valid=0, m_data=0, m_rd=0, m_regwen=0, m_fault=0, dmem_req_valid=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0; e_ready=1 after reset deasserts. In-flight request abandoned; late responses ignored.
- Non-memory / fault: accepted at edge N, m_valid at N+1.
- Store, ready=1: accept N, req_valid during cycle N+1, m_valid N+2.
- Load, ready=1, response 1 cycle after handshake: accept N, REQ N+1, rsp N+2, m_valid N+3. Response earliest the cycle after request handshake.
- Back-pressure: m_ready=0 holds m_* unchanged and e_ready=0; m_ready=1 with m_valid allows same-cycle accept (full throughput for ALU ops: one per cycle).
- dmem_req_valid never drops before handshake.

## Test plan
- addi-style pass-through: e_res=150, rd=10, regwen=1, m_ready=1 -> m_valid next cycle, m_data=150, m_regwen=1; back-to-back second op e_res=200 -> m_data=200 following cycle.
- SB addr 0x102, rs2=0x000000AB -> dmem_addr=0x100, wstrb=0100, wdata=0xABABABAB, we=1; m_regwen=0.
- LB addr 0x103, rsp 0x80FF1234 -> m_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LW 0x100 -> 0x80FF1234.
- LW addr 0x102 and LH addr 0x101 -> m_fault=1, m_regwen=0, dmem_req_valid never asserted.
- dmem_req_ready low 3 cycles, m_ready low 2 cycles -> request fields stable, m_* held, e_ready=0 throughout.
- reset asserted in WAIT, rsp_valid pulsed after -> all outputs 0, no m_valid, next ALU op completes normally.
